// File: rtl/aes_dec_round_sequencer_if.sv
// Bus bundle for aes_dec_round_sequencer: key-store write port, ciphertext
// input stream, plaintext output stream, status and FSM debug taps.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both 1. The producer holds valid and data stable until that edge and
// never withdraws valid early. The consumer may drive ready at any time;
// ready never depends combinationally on valid. key_wr_en is a write strobe
// qualified by key_ready on the same edge, and is otherwise dropped.
interface aes_dec_round_sequencer_if;
    logic         key_wr_en;
    logic [3:0]   key_wr_idx;
    logic [127:0] key_wr_data;
    logic         key_ready;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [1:0]   dbgState;
    logic [3:0]   dbgCnt;

    modport master (
        output key_wr_en, key_wr_idx, key_wr_data, in_valid, in_data, out_ready,
        input  key_ready, in_ready, out_valid, out_data, busy, dbgState, dbgCnt
    );

    modport slave (
        input  key_wr_en, key_wr_idx, key_wr_data, in_valid, in_data, out_ready,
        output key_ready, in_ready, out_valid, out_data, busy, dbgState, dbgCnt
    );
endinterface

// File: rtl/aes_dec_round_sequencer.sv
// Iterative AES inverse cipher: one shared decryptRound datapath for rounds
// NR-1..1, a final round without inverse MixColumns, and an (NR+1)-entry
// round-key store. One block in flight; IDLE -> ROUND -> FINAL -> DONE.
// Optional: define AES_DEC_ABORT_EN to add an abort input that drops the
// in-flight block and returns to IDLE.
module aes_dec_round_sequencer #(
    parameter int NR = 10
) (
    input  logic clk,
    input  logic rst_n,
`ifdef AES_DEC_ABORT_EN
    input  logic abort,
`endif
    aes_dec_round_sequencer_if.slave bus
);
    localparam logic [3:0] LAST_IDX = 4'(NR);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} seqState_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), via a short addition chain
    function automatic logic [7:0] gfInv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gfMul(x, x);
        x3   = gfMul(x2, x);
        x6   = gfMul(x3, x3);
        x12  = gfMul(x6, x6);
        x15  = gfMul(x12, x3);
        x30  = gfMul(x15, x15);
        x60  = gfMul(x30, x30);
        x120 = gfMul(x60, x60);
        x240 = gfMul(x120, x120);
        return gfMul(gfMul(x240, x12), x2);
    endfunction

    // Inverse S-box: inverse affine transform, then field inverse
    function automatic logic [7:0] invSbox(input logic [7:0] y);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b[i] = y[(i + 2) % 8] ^ y[(i + 5) % 8] ^ y[(i + 7) % 8];
        end
        return gfInv(b ^ 8'h05);
    endfunction

    // Byte k of the block is state[row k%4][col k/4], MSB first
    function automatic logic [127:0] invShiftSub(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (row + 4 * ((c + row) % 4)) -: 8] =
                    invSbox(s[127 - 8 * (row + 4 * c) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] invMixColumns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            r[127 - 32 * c -: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
            r[119 - 32 * c -: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
            r[111 - 32 * c -: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
            r[103 - 32 * c -: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
        end
        return r;
    endfunction

    logic [127:0] roundKey [0:NR];
    seqState_t    fsmState, fsmNext;
    logic [3:0]   cnt, cntNext;
    logic [127:0] blockReg, blockNext;
    logic         outValid, outValidNext;
    logic         isIdle, keyWrHit;
    logic [127:0] lastKey, shifted;

    assign isIdle   = (fsmState == IDLE);
    assign keyWrHit = bus.key_wr_en && isIdle && (bus.key_wr_idx <= LAST_IDX);
    // A same-cycle write to rk[NR] must reach the initial AddRoundKey
    assign lastKey  = (keyWrHit && bus.key_wr_idx == LAST_IDX) ? bus.key_wr_data : roundKey[NR];
    // Shared front half of both the middle rounds and the final round
    assign shifted  = invShiftSub(blockReg);

    // Round-key store; not reset so keys survive rst_n
    always_ff @(posedge clk) begin
        if (keyWrHit) roundKey[bus.key_wr_idx] <= bus.key_wr_data;
    end

    // Sequencer state, round counter, block register and output-valid flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsmState <= IDLE;
            cnt      <= 4'd0;
            blockReg <= '0;
            outValid <= 1'b0;
        end else begin
            fsmState <= fsmNext;
            cnt      <= cntNext;
            blockReg <= blockNext;
            outValid <= outValidNext;
        end
    end

    // Next-state, counter and datapath selection
    always_comb begin
        fsmNext      = fsmState;
        cntNext      = cnt;
        blockNext    = blockReg;
        outValidNext = outValid;
        case (fsmState)
            IDLE: begin
                if (bus.in_valid) begin
                    blockNext = bus.in_data ^ lastKey;
                    cntNext   = LAST_IDX - 4'd1;
                    fsmNext   = ROUND;
                end
            end
            ROUND: begin
                blockNext = invMixColumns(shifted ^ roundKey[cnt]);
                if (cnt == 4'd1) fsmNext = FINAL;
                else             cntNext = cnt - 4'd1;
            end
            FINAL: begin
                blockNext    = shifted ^ roundKey[0];
                outValidNext = 1'b1;
                fsmNext      = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    outValidNext = 1'b0;
                    fsmNext      = IDLE;
                end
            end
            default: fsmNext = IDLE;
        endcase
`ifdef AES_DEC_ABORT_EN
        // Abort outranks out_ready; ignored in IDLE so an accept still goes through
        if (abort && !isIdle) begin
            fsmNext      = IDLE;
            cntNext      = 4'd0;
            blockNext    = '0;
            outValidNext = 1'b0;
        end
`endif
    end

    assign bus.key_ready = isIdle;
    assign bus.in_ready  = isIdle;
    assign bus.busy      = !isIdle;
    assign bus.out_valid = outValid;
    assign bus.out_data  = blockReg;
    assign bus.dbgState  = fsmState;
    assign bus.dbgCnt    = cnt;
endmodule

// File: doc/aes_dec_round_sequencer.md
Name: aes_dec_round_sequencer

Overview:
- Iterative AES inverse-cipher controller. Reuses one decryptRound instance for rounds NR-1..1, plus a final-round path (inverseShiftRows -> inverseSubBytes -> addRoundKey, no inverse MixColumns).
- Owns an (NR+1) x 128-bit round-key store loaded by the key-expansion logic.
- Sequences one 128-bit block per operation through a valid/ready handshake on input and on output.

Parameters:
- NR, 10, number of AES rounds (10/12/14); key store depth NR+1; round counter width 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_wr_en  input  1  round-key write strobe.
- key_wr_idx  input  4  round-key index, 0..NR.
- key_wr_data  input  128  round-key value.
- key_ready  output  1  key store writable (high only in IDLE).
- in_valid  input  1  ciphertext block valid.
- in_ready  output  1  sequencer can accept a block (high only in IDLE).
- in_data  input  128  ciphertext.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  downstream accepts plaintext.
- out_data  output  128  plaintext.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; round counter=0; state register=0; out_data=0.
  - out_valid=0, busy=0, in_ready=1, key_ready=1.
  - Key store is not cleared.
- Key store:
  - Write occurs on key_wr_en && key_ready && key_wr_idx<=NR.
  - Writes with key_ready=0 or idx>NR are dropped silently.
  - A write in the same cycle as an in_valid accept completes; the new key is visible to that block.
- FSM: IDLE -> ROUND -> FINAL -> DONE -> IDLE.
  - IDLE:
    - On in_valid && in_ready: state_reg <= in_data ^ rk[NR]; cnt <= NR-1; go to ROUND.
  - ROUND (one cycle per round):
    - state_reg <= decryptRound(state_reg, rk[cnt]).
    - If cnt==1, go to FINAL; else cnt <= cnt-1.
  - FINAL:
    - state_reg <= addRoundKey(inverseSubBytes(inverseShiftRows(state_reg)), rk[0]).
    - Go to DONE.
  - DONE:
    - out_valid=1; out_data=state_reg, held stable while out_ready=0.
    - On out_ready, go to IDLE.
- Latency:
  - Accept in cycle T; out_valid rises in cycle T+NR+1 (T+11 for NR=10).
  - Back-to-back throughput is one block per NR+2 cycles when out_ready is held high.
- in_ready=0 and key_ready=0 in ROUND, FINAL and DONE. in_valid during those states is ignored (not queued).
- Outputs are registered: out_valid and out_data come from flops. in_ready, key_ready and busy decode directly from the state register.
- Reset mid-operation: the block is discarded, state returns to IDLE, no out_valid pulse is emitted.
- Counter never wraps: cnt is only decremented in ROUND with cnt>=2.

Optional Feature:
- Macro: AES_DEC_ABORT_EN.
- With the macro defined:
  - Adds input port abort (1 bit).
  - abort=1 in ROUND, FINAL or DONE forces the next state to IDLE and clears cnt, state_reg and out_valid on the next edge. The in-flight block is lost.
  - abort in IDLE has no effect and does not block a simultaneous accept.
  - abort has priority over out_ready in DONE.
- Without the macro: no abort port; operations always run to completion.

Test Plan:
- FIPS-197 known answer:
  - Stimulus: load rk[0]=000102030405060708090a0b0c0d0e0f through rk[10]=13111d7fe3944a17f307a78b4d2b30c5 (full expansion of key 000102..0f); send in_data=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: out_data=00112233445566778899aabbccddeeff, out_valid at T+11.
- Output backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Response: out_data stable, in_ready=0 throughout; accept resumes the cycle after out_ready=1.
- Busy lockout:
  - Stimulus: key_wr_en with idx=10, data=0, during ROUND; also pulse in_valid during ROUND.
  - Response: both ignored; a repeat of the known-answer block still yields 00112233...eeff.
- Back-to-back throughput:
  - Stimulus: two ciphertext blocks with in_valid and out_ready held high.
  - Response: two correct plaintexts; second accept 12 cycles after the first; exactly two out_valid cycles.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 at cnt=5.
  - Response: out_valid=0 immediately, in_ready=1 after release, key store intact (known answer passes without reload).
- AES_DEC_ABORT_EN:
  - Stimulus: abort=1 in ROUND at cnt=3.
  - Response: IDLE next cycle, no out_valid; the next block decrypts correctly.
